mul_arbiter: RTL and testbench

Shares one combinational `multiplier` instance among NREQ independent requesters. Each requester uses a valid/ready handshake. The block grants at most one requester per cycle, round-robin. The product is captured, tagged with the requester index, and presented on a single response port that honours backpressure. It sits between the scalar execution lanes and the shared multiplier, so the lanes never instantiate their own.

---
 rtl/mul_pkg.sv | 10 +
 rtl/mul_arbiter_if.sv | 25 ++
 rtl/multiplier.sv | 16 +
 rtl/rr_pick.sv | 20 ++
 rtl/mul_arbiter.sv | 67 ++++++
 tb/tb_mul_arbiter.sv | 155 +++++++++++++++
 6 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, index-width helper and response-state encoding
package mul_pkg;
    localparam int WIDTH_DEF = 8;

    function automatic int idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {ST_EMPTY, ST_FULL} rsp_state_e;
endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester-side handshakes and the single response port
interface mul_arbiter_if import mul_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IDW = idw(NREQ);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sign;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_product;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_product, rsp_id
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_product, rsp_id
    );
endinterface

// File: rtl/multiplier.sv
// multiplier: exact combinational WIDTH x WIDTH multiply, signed or unsigned
module multiplier #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic [2*WIDTH-1:0] product
);
    logic [2*WIDTH-1:0] ax, bx;

    // Extending to full width first makes the modular product exact for both signednesses
    assign ax = {{WIDTH{sign & a[WIDTH-1]}}, a};
    assign bx = {{WIDTH{sign & b[WIDTH-1]}}, b};
    assign product = ax * bx;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick import mul_pkg::*; #(
    parameter int NREQ = 4,
    localparam int IDW = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = |req;
        // Scan farthest-first so the closest request to ptr overwrites last
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) idx = IDW'((int'(ptr) + k) % NREQ);
        gnt = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multiplier among NREQ requesters
module mul_arbiter import mul_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);
    localparam int IDW = idw(NREQ);

    rsp_state_e         st, st_nx;
    logic [IDW-1:0]     ptr, gid, id_q;
    logic [NREQ-1:0]    gnt;
    logic               any, can_accept, hs;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               s_sel;
    logic [2*WIDTH-1:0] prod, prod_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gid),
        .any (any)
    );

    assign can_accept    = st == ST_EMPTY || bus.rsp_ready;
    assign hs            = rst_n && can_accept && any;
    assign bus.req_ready = (rst_n && can_accept) ? gnt : '0;

    assign a_sel = bus.req_a[int'(gid)*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[int'(gid)*WIDTH +: WIDTH];
    assign s_sel = bus.req_sign[gid];

    multiplier #(.WIDTH(WIDTH)) u_mul (
        .a       (a_sel),
        .b       (b_sel),
        .sign    (s_sel),
        .product (prod)
    );

    always_comb begin
        st_nx = hs ? ST_FULL : (bus.rsp_ready ? ST_EMPTY : st);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_EMPTY;
        else        st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            id_q   <= '0;
            ptr    <= '0;
        end else if (hs) begin
            prod_q <= prod;
            id_q   <= gid;
            ptr    <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
        end
    end

    assign bus.rsp_valid   = st == ST_FULL;
    assign bus.rsp_product = prod_q;
    assign bus.rsp_id      = id_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed stimulus with a queue scoreboard checked by a response monitor
module tb_mul_arbiter;
    import mul_pkg::*;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    logic [7:0] rr_a [4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    logic [7:0] rr_b [4] = '{8'd5, 8'd7, 8'd9, 8'd11};
    logic [15:0] rr_p [4] = '{16'd15, 16'd28, 16'd45, 16'd66};

    mul_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    mul_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.req_valid[i] = 1'b1;
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_sign[i] = s;
    endtask

    task automatic push(input int id, input logic [15:0] p);
        exp_t e;
        e.id = 2'(id);
        e.p  = p;
        q.push_back(e);
    endtask

    // Every accepted response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {14'd0, bus.rsp_id, bus.rsp_product}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_product", 32'(bus.rsp_product), 32'(e.p));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_sign = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_product", 32'(bus.rsp_product), 32'h0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        bus.req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("idle_req_ready", 32'(bus.req_ready), 32'h0);
            chk("idle_rsp_product", 32'(bus.rsp_product), 32'h0);
            chk("idle_rsp_id", 32'(bus.rsp_id), 32'h0);
        end

        // Single-requester directed vectors; ptr ends at 0 after requester 3
        @(posedge clk); #1 set_req(0, 8'd42, 8'd42, 1'b1); push(0, 16'd1764);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); chk("lat1_valid", 32'(bus.rsp_valid), 32'h1);
        @(posedge clk); #1 set_req(2, 8'hD6, 8'd7, 1'b1); push(2, 16'hFEDA);
        @(posedge clk); #1 set_req(1, 8'hC8, 8'hC8, 1'b0); bus.req_valid[2] = 1'b0; push(1, 16'h9C40);
        @(posedge clk); #1 set_req(1, 8'hC8, 8'hC8, 1'b1); push(1, 16'h0C40);
        @(posedge clk); #1 set_req(3, 8'hFF, 8'hFF, 1'b0); bus.req_valid[1] = 1'b0; push(3, 16'hFE01);
        @(posedge clk); #1 set_req(3, 8'h80, 8'h80, 1'b1); push(3, 16'h4000);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (2) @(posedge clk);

        // All four continuously valid: strict rotation, one grant per cycle
        #1;
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], 1'b0);
        for (int k = 0; k < 8; k++) push(k % 4, rr_p[k % 4]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk);
        end
        #1 bus.req_valid = '0;
        repeat (2) @(posedge clk);

        // Backpressure with requesters 1 and 3 waiting
        #1 bus.rsp_ready = 1'b0; set_req(0, 8'd2, 8'd3, 1'b0);
        push(0, 16'd6); push(1, 16'd110); push(3, 16'd156);
        @(posedge clk); #1 bus.req_valid = '0; set_req(1, 8'd10, 8'd11, 1'b0); set_req(3, 8'd12, 8'd13, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_product", 32'(bus.rsp_product), 32'd6);
            chk("bp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk); chk("bp_release_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1 bus.req_valid[1] = 1'b0;
        @(negedge clk); chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
        @(posedge clk); #1 bus.req_valid[3] = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while FULL with ptr=2: held result discarded, next grant to 0
        #1 bus.rsp_ready = 1'b0; set_req(1, 8'd5, 8'd5, 1'b0);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); chk("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("async_rst_product", 32'(bus.rsp_product), 32'h0);
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], 1'b0);
        bus.rsp_ready = 1'b1;
        #1 chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1; push(0, 16'd15);
        @(negedge clk); chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1 bus.req_valid = '0;

        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
